// File: rtl/quadc_snap_pkg.sv
// Shared types and widths for the quad-ADC snapshot controller.
package quadc_snap_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // adc0 lands in the most significant byte of the stored word.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [SAMPLE_W-1:0] a0,
    input logic [SAMPLE_W-1:0] a1,
    input logic [SAMPLE_W-1:0] a2,
    input logic [SAMPLE_W-1:0] a3
  );
    return {a0, a1, a2, a3};
  endfunction

endpackage

// File: rtl/quadc_snap_if.sv
// Sample stream from the capture interface plus the BRAM write bus.
interface quadc_snap_if #(
  parameter int unsigned ADDR_W = 10
);
  import quadc_snap_pkg::*;

  logic [SAMPLE_W-1:0] adc0_data;
  logic [SAMPLE_W-1:0] adc1_data;
  logic [SAMPLE_W-1:0] adc2_data;
  logic [SAMPLE_W-1:0] adc3_data;
  logic                valid;
  logic                sync;

  logic                bram_we;
  logic [ADDR_W-1:0]   bram_addr;
  logic [WORD_W-1:0]   bram_data;

  // Sample source side: drives the stream, observes the BRAM writes.
  modport master (
    output adc0_data, adc1_data, adc2_data, adc3_data, valid, sync,
    input  bram_we, bram_addr, bram_data
  );

  // Snapshot controller side: consumes the stream, drives the BRAM writes.
  modport slave (
    input  adc0_data, adc1_data, adc2_data, adc3_data, valid, sync,
    output bram_we, bram_addr, bram_data
  );

endinterface

// File: rtl/quadc_sync_edge.sv
// Valid-qualified rising-edge detector on the sync flag.
module quadc_sync_edge (
  input  logic user_clk,
  input  logic reset,
  input  logic valid,
  input  logic sync,
  output logic sync_edge
);

  logic r_sync_prev;

  // Remember sync from the most recent valid sample only.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_sync_prev <= 1'b0;
    end else if (valid) begin
      r_sync_prev <= sync;
    end
  end

  // Edge between two consecutive valid samples; reset value 0 makes a
  // high sync on the first valid sample count as an edge.
  always_comb begin
    sync_edge = valid && sync && !r_sync_prev;
  end

endmodule

// File: rtl/quadc_snap_ctrl.sv
// Snapshot controller: captures len_m1+1 valid samples into BRAM on arm,
// immediately or from a sync rising edge.
module quadc_snap_ctrl
  import quadc_snap_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              reset,
  quadc_snap_if.slave       bus,
  input  logic              arm,
  input  logic              trig_sel,
  input  logic [ADDR_W-1:0] len_m1,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words
);

  state_t              r_state;
  state_t              w_next;

  logic                r_trig_sel;
  logic [ADDR_W-1:0]   r_len_m1;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_words;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_data;

  logic                w_edge;
  logic                w_trig;
  logic                w_last;
  logic                w_accept;
  logic [ADDR_W:0]     w_len_words;

  quadc_sync_edge u_sync_edge (
    .user_clk  (user_clk),
    .reset     (reset),
    .valid     (bus.valid),
    .sync      (bus.sync),
    .sync_edge (w_edge)
  );

  // Decide whether this cycle's sample is written; arm always wins.
  always_comb begin
    w_trig      = bus.valid && (!r_trig_sel || w_edge);
    w_last      = (r_ptr == r_len_m1);
    w_len_words = {1'b0, r_len_m1} + {{ADDR_W{1'b0}}, 1'b1};
    w_accept    = 1'b0;
    case (r_state)
      ST_ARMED:   w_accept = w_trig && !arm;
      ST_CAPTURE: w_accept = bus.valid && !arm;
      default:    w_accept = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; arm restarts from any state.
  always_comb begin
    w_next = r_state;
    if (arm) begin
      w_next = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED, ST_CAPTURE: begin
          if (w_accept) begin
            w_next = w_last ? ST_DONE : ST_CAPTURE;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  // State-decoded status outputs.
  always_comb begin
    busy = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    done = (r_state == ST_DONE);
  end

  // Parameter latch, write pointer, word count and registered BRAM port.
  // The pointer holds on the final write so it never wraps mid-snapshot.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_trig_sel <= 1'b0;
      r_len_m1   <= '0;
      r_ptr      <= '0;
      r_words    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_we <= w_accept;
      if (arm) begin
        r_trig_sel <= trig_sel;
        r_len_m1   <= len_m1;
        r_ptr      <= '0;
        r_words    <= '0;
      end else if (w_accept) begin
        r_addr <= r_ptr;
        r_data <= pack_word(bus.adc0_data, bus.adc1_data,
                            bus.adc2_data, bus.adc3_data);
        if (!w_last) begin
          r_ptr <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (r_words != w_len_words) begin
          r_words <= r_words + {{ADDR_W{1'b0}}, 1'b1};
        end
      end
    end
  end

  assign bus.bram_we   = r_we;
  assign bus.bram_addr = r_addr;
  assign bus.bram_data = r_data;
  assign words         = r_words;

endmodule

// File: tb/tb_quadc_snap_ctrl.sv
// Directed self-checking bench for quadc_snap_ctrl (ADDR_W = 4).
module tb_quadc_snap_ctrl;
  import quadc_snap_pkg::*;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset;
  logic          arm;
  logic          trig_sel;
  logic [AW-1:0] len_m1;
  logic          busy;
  logic          done;
  logic [AW:0]   words;

  int n_checks;
  int n_fail;
  int n_overlap;

  logic [AW-1:0] q_addr[$];
  logic [31:0]   q_data[$];

  quadc_snap_if #(.ADDR_W(AW)) bus ();

  quadc_snap_ctrl #(.ADDR_W(AW)) dut (
    .user_clk (clk),
    .reset    (reset),
    .bus      (bus),
    .arm      (arm),
    .trig_sel (trig_sel),
    .len_m1   (len_m1),
    .busy     (busy),
    .done     (done),
    .words    (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] smp(input int b);
    logic [7:0] x;
    x = 8'(b);
    return {x, x + 8'd1, x + 8'd2, x + 8'd3};
  endfunction

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    bus.valid     = v;
    bus.sync      = s;
    bus.adc0_data = d[31:24];
    bus.adc1_data = d[23:16];
    bus.adc2_data = d[15:8];
    bus.adc3_data = d[7:0];
  endtask

  // Advance one clock, sample 1 time unit after the edge, log writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.bram_we === 1'b1) begin
      q_addr.push_back(bus.bram_addr);
      q_data.push_back(bus.bram_data);
    end
    if (busy === 1'b1 && done === 1'b1) n_overlap++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_overlap = 0;
    reset     = 1'b1;
    arm       = 1'b0;
    trig_sel  = 1'b0;
    len_m1    = '0;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_we",    32'(bus.bram_we),   32'd0);
    chk("rst_addr",  32'(bus.bram_addr), 32'd0);
    chk("rst_data",  bus.bram_data,      32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_done",  32'(done),          32'd0);
    chk("rst_words", 32'(words),         32'd0);
    reset = 1'b0;
    tick();

    // Immediate mode, 4 words.
    arm = 1'b1; trig_sel = 1'b0; len_m1 = 4'd3;
    tick();
    arm = 1'b0;
    chk("imm_busy_after_arm", 32'(busy), 32'd1);
    chk("imm_no_we_on_arm",   32'(bus.bram_we), 32'd0);
    clr();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, smp(i));
      tick();
      if (i == 3) begin
        chk("imm_done_with_last_we", 32'({bus.bram_we, done}), 32'h3);
        chk("imm_last_addr", 32'(bus.bram_addr), 32'd3);
      end
    end
    chk("imm_nwrites", 32'(q_addr.size()), 32'd4);
    for (int j = 0; j < 4; j++) chk("imm_addr", 32'(q_addr[j]), 32'(j));
    chk("imm_data0", q_data[0], 32'h00010203);
    chk("imm_data3", q_data[3], 32'h03040506);
    chk("imm_done",  32'(done),  32'd1);
    chk("imm_words", 32'(words), 32'd4);
    chk("imm_busy",  32'(busy),  32'd0);

    // Sync trigger, edge on the 5th valid sample.
    drive(1'b0, 1'b0, 32'h0);
    arm = 1'b1; trig_sel = 1'b1; len_m1 = 4'd7;
    tick();
    arm = 1'b0;
    clr();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i >= 4), smp(8'h40 + i));
      tick();
      if (i == 3) chk("sync_no_early_write", 32'(q_addr.size()), 32'd0);
    end
    chk("sync_nwrites", 32'(q_addr.size()), 32'd8);
    chk("sync_data0",   q_data[0], 32'h44454647);
    chk("sync_addr0",   32'(q_addr[0]), 32'd0);
    chk("sync_data7",   q_data[7], 32'h4b4c4d4e);
    chk("sync_addr7",   32'(q_addr[7]), 32'd7);
    chk("sync_words",   32'(words), 32'd8);
    chk("sync_done",    32'(done),  32'd1);

    // Valid gaps.
    drive(1'b0, 1'b0, 32'h0);
    arm = 1'b1; trig_sel = 1'b0; len_m1 = 4'd3;
    tick();
    arm = 1'b0;
    clr();
    for (int k = 0; k < 7; k++) begin
      drive((k % 2 == 0), 1'b0, smp(8'h80 + k));
      tick();
      chk("gap_we", 32'(bus.bram_we), 32'((k % 2) == 0));
      if (k == 5) chk("gap_not_done_early", 32'(done), 32'd0);
    end
    chk("gap_done",    32'(done), 32'd1);
    chk("gap_nwrites", 32'(q_addr.size()), 32'd4);
    for (int j = 0; j < 4; j++) chk("gap_addr", 32'(q_addr[j]), 32'(j));
    chk("gap_data1", q_data[1], 32'h82838485);
    chk("gap_data3", q_data[3], 32'h86878889);

    // Full length: 16 words with a 4-bit address.
    drive(1'b0, 1'b0, 32'h0);
    arm = 1'b1; trig_sel = 1'b0; len_m1 = 4'd15;
    tick();
    arm = 1'b0;
    clr();
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, 1'b0, smp(k));
      tick();
      if (k == 14) chk("full_not_done_early", 32'(done), 32'd0);
      if (k == 15) begin
        chk("full_last_we",   32'(bus.bram_we),   32'd1);
        chk("full_last_addr", 32'(bus.bram_addr), 32'd15);
        chk("full_done_with_last", 32'(done),     32'd1);
      end
      if (k == 17) chk("full_no_extra_we", 32'(bus.bram_we), 32'd0);
    end
    chk("full_nwrites", 32'(q_addr.size()), 32'd16);
    for (int j = 0; j < 16; j++) chk("full_addr", 32'(q_addr[j]), 32'(j));
    chk("full_words", 32'(words), 32'd16);

    // Re-arm mid-capture, then reset mid-snapshot.
    drive(1'b0, 1'b0, 32'h0);
    arm = 1'b1; trig_sel = 1'b0; len_m1 = 4'd7;
    tick();
    arm = 1'b0;
    clr();
    drive(1'b1, 1'b0, smp(8'h90)); tick();
    drive(1'b1, 1'b0, smp(8'h91)); tick();
    chk("rearm_pre_nwrites", 32'(q_addr.size()), 32'd2);
    chk("rearm_pre_words",   32'(words), 32'd2);
    arm = 1'b1;
    drive(1'b1, 1'b0, smp(8'hA0));
    tick();
    arm = 1'b0;
    chk("rearm_sample_dropped", 32'(bus.bram_we), 32'd0);
    chk("rearm_words_cleared",  32'(words), 32'd0);
    chk("rearm_busy",           32'(busy),  32'd1);
    clr();
    drive(1'b1, 1'b0, smp(8'hB0));
    tick();
    chk("rearm_addr0", 32'(bus.bram_addr), 32'd0);
    chk("rearm_data0", bus.bram_data, 32'hb0b1b2b3);
    chk("rearm_words1", 32'(words), 32'd1);
    drive(1'b1, 1'b0, smp(8'hB1)); tick();
    drive(1'b1, 1'b0, smp(8'hB2)); tick();
    chk("rearm_nwrites", 32'(q_addr.size()), 32'd3);
    reset = 1'b1;
    drive(1'b1, 1'b0, smp(8'hC0));
    tick();
    chk("mid_rst_we",    32'(bus.bram_we),   32'd0);
    chk("mid_rst_addr",  32'(bus.bram_addr), 32'd0);
    chk("mid_rst_data",  bus.bram_data,      32'd0);
    chk("mid_rst_busy",  32'(busy),          32'd0);
    chk("mid_rst_done",  32'(done),          32'd0);
    chk("mid_rst_words", 32'(words),         32'd0);
    reset = 1'b0;
    clr();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, smp(8'hC1 + k));
      tick();
    end
    chk("post_rst_nwrites", 32'(q_addr.size()), 32'd0);
    chk("post_rst_busy",    32'(busy), 32'd0);

    // Single word on a sync edge.
    drive(1'b0, 1'b0, 32'h0);
    arm = 1'b1; trig_sel = 1'b1; len_m1 = 4'd0;
    tick();
    arm = 1'b0;
    chk("one_busy_armed", 32'(busy), 32'd1);
    clr();
    drive(1'b1, 1'b0, smp(8'hD0));
    tick();
    chk("one_no_we_before_edge", 32'(bus.bram_we), 32'd0);
    chk("one_still_armed",       32'(busy),        32'd1);
    drive(1'b1, 1'b1, smp(8'hD1));
    tick();
    chk("one_we",    32'(bus.bram_we),   32'd1);
    chk("one_addr",  32'(bus.bram_addr), 32'd0);
    chk("one_data",  bus.bram_data,      32'hd1d2d3d4);
    chk("one_done",  32'(done),          32'd1);
    chk("one_busy",  32'(busy),          32'd0);
    chk("one_words", 32'(words),         32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, smp(8'hE0 + k));
      tick();
    end
    chk("one_nwrites", 32'(q_addr.size()), 32'd1);
    chk("busy_done_overlap", 32'(n_overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
